// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state encoding, line-mux select codes and parameter limits for the UART TX engine.
package uart_tx_pkg;
    typedef logic [2:0] state_t;
    typedef logic [1:0] sel_t;

    localparam state_t S_IDLE   = 3'b000;
    localparam state_t S_START  = 3'b001;
    localparam state_t S_DATA   = 3'b010;
    localparam state_t S_PARITY = 3'b011;
    localparam state_t S_STOP   = 3'b100;

    localparam sel_t SEL_START  = 2'b00;
    localparam sel_t SEL_DATA   = 2'b01;
    localparam sel_t SEL_PARITY = 2'b10;
    localparam sel_t SEL_IDLE   = 2'b11;

    localparam int DW_MIN  = 5;
    localparam int DW_MAX  = 9;
    localparam int CPB_MIN = 1;

    function automatic sel_t line_sel(input state_t st);
        return st == S_START  ? SEL_START  :
               st == S_DATA   ? SEL_DATA   :
               st == S_PARITY ? SEL_PARITY : SEL_IDLE;
    endfunction
endpackage

// File: rtl/uart_tx_engine_if.sv
// uart_tx_engine_if: word/config request side and serial/status side of the UART TX engine.
interface uart_tx_engine_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic                  TX_OUT;
    logic                  busy;
    logic                  tx_done;

    modport master (
        output P_DATA, data_valid, PAR_EN, PAR_TYP, STOP2,
        input  TX_OUT, busy, tx_done
    );
    modport slave (
        input  P_DATA, data_valid, PAR_EN, PAR_TYP, STOP2,
        output TX_OUT, busy, tx_done
    );
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_bit_end
);
    localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;

    logic [W-1:0] r_cnt;

    assign o_bit_end = i_en && r_cnt == W'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk) begin
        if (reset || i_clear || o_bit_end)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: framed UART transmitter (start, LSB-first data, optional parity, 1/2 stop bits).
module uart_tx_engine
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input logic             clk,
    input logic             reset,
    uart_tx_engine_if.slave bus
);
    localparam int IW = $clog2(DATA_WIDTH);

    state_t                r_state, w_nstate;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic [IW-1:0]         r_bit_idx;
    logic                  r_par_en, r_stop2, r_par, r_stop_idx, r_tx;
    logic                  w_bit_end, w_last_data, w_last_stop, w_done, w_accept, w_line;
    sel_t                  w_sel;

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_accept),
        .i_en      (r_state != S_IDLE),
        .o_bit_end (w_bit_end)
    );

    assign w_last_data = r_bit_idx == IW'(DATA_WIDTH - 1);
    assign w_last_stop = !r_stop2 || r_stop_idx;
    assign w_done      = r_state == S_STOP && w_bit_end && w_last_stop;
    assign w_accept    = bus.data_valid && (r_state == S_IDLE || w_done);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = S_IDLE;
        case (r_state)
            S_IDLE:   w_nstate = w_accept ? S_START : S_IDLE;
            S_START:  w_nstate = w_bit_end ? S_DATA : S_START;
            S_DATA:   w_nstate = !(w_bit_end && w_last_data) ? S_DATA : r_par_en ? S_PARITY : S_STOP;
            S_PARITY: w_nstate = w_bit_end ? S_STOP : S_PARITY;
            S_STOP:   w_nstate = !w_done ? S_STOP : w_accept ? S_START : S_IDLE;
            default:  w_nstate = S_IDLE;
        endcase
    end

    // TX_OUT is registered from the next state so the line value lines up with r_state
    always_comb begin
        w_shift_nxt = w_accept ? bus.P_DATA :
                      (r_state == S_DATA && w_bit_end) ? r_shift >> 1 : r_shift;
        w_sel       = line_sel(w_nstate);
        w_line      = w_sel == SEL_START  ? 1'b0 :
                      w_sel == SEL_DATA   ? w_shift_nxt[0] :
                      w_sel == SEL_PARITY ? r_par : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_par_en   <= 1'b0;
            r_stop2    <= 1'b0;
            r_par      <= 1'b0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_shift <= w_shift_nxt;
            r_tx    <= w_line;
            if (w_accept) begin
                r_bit_idx  <= '0;
                r_stop_idx <= 1'b0;
                r_par_en   <= bus.PAR_EN;
                r_stop2    <= bus.STOP2;
                r_par      <= ^bus.P_DATA ^ bus.PAR_TYP;
            end else begin
                if (r_state == S_DATA && w_bit_end)
                    r_bit_idx <= r_bit_idx + 1'b1;
                if (r_state == S_STOP && w_bit_end)
                    r_stop_idx <= 1'b1;
            end
        end
    end

    assign bus.TX_OUT  = r_tx;
    assign bus.busy    = r_state != S_IDLE;
    assign bus.tx_done = w_done;
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: table-driven frame checks plus reset, back-to-back, ignore and 1-clock-per-bit sequences.
module tb_uart_tx_engine;
    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic        s2;
        int          nbits;
        logic [11:0] frame;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs[8];

    always #5 clk = ~clk;

    uart_tx_engine_if #(.DATA_WIDTH(8)) bus ();
    uart_tx_engine_if #(.DATA_WIDTH(8)) bus1 ();

    uart_tx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    uart_tx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " tx"}, {31'd0, bus.TX_OUT}, 32'd1);
        chk({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, " done"}, {31'd0, bus.tx_done}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   len, nbusy, ndone, tdone;
        logic expb;
        len   = v.nbits * 4;
        nbusy = 0;
        ndone = 0;
        tdone = 0;
        chk($sformatf("vec%0d pre busy", idx), {31'd0, bus.busy}, 32'd0);
        bus.P_DATA     = v.data;
        bus.PAR_EN     = v.pe;
        bus.PAR_TYP    = v.pt;
        bus.STOP2      = v.s2;
        bus.data_valid = 1'b1;
        tick();
        for (int c = 1; c <= len + 3; c++) begin
            expb = c <= len ? v.frame[(c-1)/4] : 1'b1;
            chk($sformatf("vec%0d line c=%0d", idx, c), {31'd0, bus.TX_OUT}, {31'd0, expb});
            if (bus.busy) nbusy++;
            if (bus.tx_done) begin
                ndone++;
                tdone = c;
            end
            // mid-frame noise: config flipped and a stray request during data bit 3
            if (c == 1) begin
                bus.data_valid = 1'b0;
                bus.P_DATA     = ~v.data;
                bus.PAR_EN     = ~v.pe;
                bus.PAR_TYP    = ~v.pt;
                bus.STOP2      = ~v.s2;
            end
            if (c == 18) begin
                bus.data_valid = 1'b1;
                bus.P_DATA     = 8'hFF;
            end
            if (c == 19) bus.data_valid = 1'b0;
            tick();
        end
        chk($sformatf("vec%0d busy_len", idx), nbusy, len);
        chk($sformatf("vec%0d done_cnt", idx), ndone, 1);
        chk($sformatf("vec%0d done_at", idx), tdone, len);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10, 12'h34A};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11, 12'h54A};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 11, 12'h74A};
        vecs[3] = '{8'h07, 1'b1, 1'b0, 1'b0, 11, 12'h60E};
        vecs[4] = '{8'h07, 1'b1, 1'b1, 1'b0, 11, 12'h40E};
        vecs[5] = '{8'hA5, 1'b0, 1'b0, 1'b1, 11, 12'h74A};
        vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 12, 12'hE00};
        vecs[7] = '{8'hFF, 1'b1, 1'b0, 1'b0, 11, 12'h5FE};

        reset           = 1'b1;
        bus.P_DATA      = 8'hA5;
        bus.PAR_EN      = 1'b0;
        bus.PAR_TYP     = 1'b0;
        bus.STOP2       = 1'b0;
        bus.data_valid  = 1'b1;
        bus1.P_DATA     = 8'h00;
        bus1.PAR_EN     = 1'b0;
        bus1.PAR_TYP    = 1'b0;
        bus1.STOP2      = 1'b0;
        bus1.data_valid = 1'b0;

        tick();
        chk_idle("rst1");
        tick();
        chk_idle("rst2");
        reset = 1'b0;
        tick();
        chk("rst_accept busy", {31'd0, bus.busy}, 32'd1);
        chk("rst_accept tx", {31'd0, bus.TX_OUT}, 32'd0);
        bus.data_valid = 1'b0;
        for (int k = 0; k < 100 && bus.busy; k++) tick();
        chk("rst_wait_idle", {31'd0, bus.busy}, 32'd0);
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        begin : b2b
            logic [11:0] f1, f2;
            logic        expb;
            f1 = 12'h34A;
            f2 = 12'h278;
            bus.P_DATA     = 8'hA5;
            bus.PAR_EN     = 1'b0;
            bus.PAR_TYP    = 1'b0;
            bus.STOP2      = 1'b0;
            bus.data_valid = 1'b1;
            tick();
            for (int c = 1; c <= 83; c++) begin
                expb = c <= 40 ? f1[(c-1)/4] : c <= 80 ? f2[(c-41)/4] : 1'b1;
                chk($sformatf("b2b line c=%0d", c), {31'd0, bus.TX_OUT}, {31'd0, expb});
                chk($sformatf("b2b busy c=%0d", c), {31'd0, bus.busy}, {31'd0, c <= 80});
                chk($sformatf("b2b done c=%0d", c), {31'd0, bus.tx_done}, {31'd0, c == 40 || c == 80});
                if (c == 1) bus.data_valid = 1'b0;
                if (c == 40) begin
                    bus.data_valid = 1'b1;
                    bus.P_DATA     = 8'h3C;
                end
                if (c == 41) bus.data_valid = 1'b0;
                tick();
            end
        end

        bus.P_DATA     = 8'hA5;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        for (int c = 1; c < 18; c++) tick();
        chk("mid_rst pre busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        tick();
        chk_idle("mid_rst a");
        reset = 1'b0;
        tick();
        chk_idle("mid_rst b");
        tick();
        run_vec(vecs[0], 100);

        begin : cpb1
            logic [11:0] f;
            logic        expb;
            f = 12'h54A;
            bus1.P_DATA     = 8'hA5;
            bus1.PAR_EN     = 1'b1;
            bus1.PAR_TYP    = 1'b0;
            bus1.data_valid = 1'b1;
            tick();
            for (int c = 1; c <= 24; c++) begin
                expb = c <= 22 ? f[(c-1)%11] : 1'b1;
                chk($sformatf("cpb1 line c=%0d", c), {31'd0, bus1.TX_OUT}, {31'd0, expb});
                chk($sformatf("cpb1 busy c=%0d", c), {31'd0, bus1.busy}, {31'd0, c <= 22});
                chk($sformatf("cpb1 done c=%0d", c), {31'd0, bus1.tx_done}, {31'd0, c == 11 || c == 22});
                if (c == 22) bus1.data_valid = 1'b0;
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
